// File: rtl/sobel_line_scheduler_pkg.sv
// Shared definitions for the Sobel line-buffer scheduler.
//   sched_state_t      : frame fill/stream state encoding
//   LINE_WORDS_DEFAULT : default maximum words per line
//   ADDR_W / DATA_W    : buffer address and pixel word widths
//   nextRole()         : mod-3 increment used for buffer role rotation
package sobel_line_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL0,
    FILL1,
    STREAM
  } sched_state_t;

  localparam int unsigned LINE_WORDS_DEFAULT = 256;
  localparam int unsigned ADDR_W             = 8;
  localparam int unsigned DATA_W             = 16;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] pixel_t;

  function automatic logic [1:0] nextRole(input logic [1:0] role);
    return (role == 2'd2) ? 2'd0 : role + 2'd1;
  endfunction

endpackage

// File: rtl/sobel_line_scheduler_if.sv
// Bundle of the scheduler's stream, buffer and window signals.
//   master : camera stream source, buffer read data, window consumer
//   slave  : the scheduler itself (drives buffer controls and the window)
interface sobel_line_scheduler_if import sobel_line_scheduler_pkg::*; ();

  logic   frameStart;
  logic   pixelValid;
  logic   lineEnd;
  pixel_t pixelData;

  addr_t  bufAddressIn;
  logic [2:0] bufWriteEnable;
  pixel_t bufDataIn;
  addr_t  bufAddressOut;
  pixel_t bufDataOut0;
  pixel_t bufDataOut1;
  pixel_t bufDataOut2;

  pixel_t top;
  pixel_t middle;
  pixel_t bottom;
  logic   windowValid;
  addr_t  windowColumn;
  logic   lastColumn;
  logic   overflow;

  modport master (
    output frameStart, pixelValid, lineEnd, pixelData,
    output bufDataOut0, bufDataOut1, bufDataOut2,
    input  bufAddressIn, bufWriteEnable, bufDataIn, bufAddressOut,
    input  top, middle, bottom, windowValid, windowColumn, lastColumn, overflow
  );

  modport slave (
    input  frameStart, pixelValid, lineEnd, pixelData,
    input  bufDataOut0, bufDataOut1, bufDataOut2,
    output bufAddressIn, bufWriteEnable, bufDataIn, bufAddressOut,
    output top, middle, bottom, windowValid, windowColumn, lastColumn, overflow
  );

endinterface

// File: rtl/sobel_line_scheduler_window_mux.sv
// Two-stage window pipeline (module sobel_window_mux).
// Stage 1 captures the role indices of the accepted word while the buffers
// perform their registered read; stage 2 registers the selected top/middle
// words together with the delayed bottom word, column and last-column flag.
//   clock, resetN        : system clock, synchronous active-low reset
//   flush                : drops the triple currently in stage 1
//   inValid/inCur/...    : accepted word that should produce a window
//   bufDataOut0..2       : registered buffer read data
//   top/middle/bottom... : registered window outputs
module sobel_window_mux import sobel_line_scheduler_pkg::*; (
  input  logic       clock,
  input  logic       resetN,
  input  logic       flush,
  input  logic       inValid,
  input  logic [1:0] inCur,
  input  pixel_t     inBottom,
  input  addr_t      inColumn,
  input  logic       inLast,
  input  pixel_t     bufDataOut0,
  input  pixel_t     bufDataOut1,
  input  pixel_t     bufDataOut2,
  output pixel_t     top,
  output pixel_t     middle,
  output pixel_t     bottom,
  output logic       windowValid,
  output addr_t      windowColumn,
  output logic       lastColumn
);

  logic       s1Valid;
  logic [1:0] s1TopSel;
  logic [1:0] s1MidSel;
  pixel_t     s1Bottom;
  addr_t      s1Column;
  logic       s1Last;
  pixel_t     topSel;
  pixel_t     midSel;
  logic       s2Load;

  always_comb begin
    topSel = bufDataOut0;
    midSel = bufDataOut0;
    case (s1TopSel)
      2'd1:    topSel = bufDataOut1;
      2'd2:    topSel = bufDataOut2;
      default: topSel = bufDataOut0;
    endcase
    case (s1MidSel)
      2'd1:    midSel = bufDataOut1;
      2'd2:    midSel = bufDataOut2;
      default: midSel = bufDataOut0;
    endcase
    s2Load = s1Valid && !flush;
  end

  // Line n-2 lives in (cur+1) mod 3, line n-1 in (cur+2) mod 3.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      s1Valid  <= 1'b0;
      s1TopSel <= '0;
      s1MidSel <= '0;
      s1Bottom <= '0;
      s1Column <= '0;
      s1Last   <= 1'b0;
    end else begin
      s1Valid <= inValid;
      if (inValid) begin
        s1TopSel <= nextRole(inCur);
        s1MidSel <= nextRole(nextRole(inCur));
        s1Bottom <= inBottom;
        s1Column <= inColumn;
        s1Last   <= inLast;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      windowValid  <= 1'b0;
      lastColumn   <= 1'b0;
      top          <= '0;
      middle       <= '0;
      bottom       <= '0;
      windowColumn <= '0;
    end else begin
      windowValid <= s2Load;
      lastColumn  <= s2Load && s1Last;
      if (s2Load) begin
        top          <= topSel;
        middle       <= midSel;
        bottom       <= s1Bottom;
        windowColumn <= s1Column;
      end
    end
  end

endmodule

// File: rtl/sobel_line_scheduler.sv
// Sequencer for three dual-port Sobel line buffers. Writes each accepted
// pixel into the buffer holding the current line, reads the same column of
// the two previous lines, rotates buffer roles at each line end and emits a
// column-aligned top/middle/bottom triple two cycles after acceptance.
//   clock  : system clock (buffers share it)
//   resetN : synchronous active-low reset
//   bus    : stream input, buffer address/enable/data, window outputs
module sobel_line_scheduler import sobel_line_scheduler_pkg::*; #(
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEFAULT
) (
  input logic                   clock,
  input logic                   resetN,
  sobel_line_scheduler_if.slave bus
);

  localparam addr_t COL_MAX = addr_t'(LINE_WORDS - 1);

  sched_state_t state, stateNext, baseState;
  addr_t        col, colNext, baseCol;
  logic [1:0]   cur, curNext, baseCur;
  logic         full, fullNext, baseFull;
  logic         overflow, overflowNext;
  logic         take, accept, lineDone, winStart;
  logic [2:0]   writeEnable;

  // frameStart takes effect on the word of its own cycle, so every decision
  // below is made against the post-restart view (base*) of the registers.
  always_comb begin
    baseState = bus.frameStart ? FILL0 : state;
    baseCol   = bus.frameStart ? '0 : col;
    baseCur   = bus.frameStart ? 2'd0 : cur;
    baseFull  = bus.frameStart ? 1'b0 : full;

    take     = resetN && (baseState != IDLE) && bus.pixelValid;
    accept   = take && !baseFull;
    lineDone = take && bus.lineEnd;

    stateNext    = baseState;
    colNext      = baseCol;
    curNext      = baseCur;
    fullNext     = baseFull;
    overflowNext = (bus.frameStart ? 1'b0 : overflow) | (take && baseFull);

    if (lineDone) begin
      colNext  = '0;
      fullNext = 1'b0;
      curNext  = nextRole(baseCur);
      case (baseState)
        FILL0:   stateNext = FILL1;
        FILL1:   stateNext = STREAM;
        default: stateNext = baseState;
      endcase
    end else if (accept) begin
      // Column LINE_WORDS-1 has been written: hold the counter and mark the
      // line full so later words are dropped rather than overwriting it.
      if (baseCol == COL_MAX) begin
        fullNext = 1'b1;
      end else begin
        colNext = baseCol + 1'b1;
      end
    end

    writeEnable = accept ? (3'b001 << baseCur) : 3'b000;
    winStart    = accept && (baseState == STREAM);
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state    <= IDLE;
      col      <= '0;
      cur      <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= stateNext;
      col      <= colNext;
      cur      <= curNext;
      full     <= fullNext;
      overflow <= overflowNext;
    end
  end

  assign bus.bufWriteEnable = writeEnable;
  assign bus.bufAddressIn   = baseCol;
  assign bus.bufAddressOut  = baseCol;
  assign bus.bufDataIn      = bus.pixelData;
  assign bus.overflow       = overflow;

  sobel_window_mux u_window_mux (
    .clock        (clock),
    .resetN       (resetN),
    .flush        (bus.frameStart),
    .inValid      (winStart),
    .inCur        (baseCur),
    .inBottom     (bus.pixelData),
    .inColumn     (baseCol),
    .inLast       (bus.lineEnd),
    .bufDataOut0  (bus.bufDataOut0),
    .bufDataOut1  (bus.bufDataOut1),
    .bufDataOut2  (bus.bufDataOut2),
    .top          (bus.top),
    .middle       (bus.middle),
    .bottom       (bus.bottom),
    .windowValid  (bus.windowValid),
    .windowColumn (bus.windowColumn),
    .lastColumn   (bus.lastColumn)
  );

endmodule

// File: tb/tb_sobel_line_scheduler.sv
// Self-checking bench for sobel_line_scheduler with LINE_WORDS = 8.
// Three line buffers are modelled around the DUT; expected windows come from
// a per-line history of sent pixels indexed by line number within the frame.
module tb_sobel_line_scheduler;
  import sobel_line_scheduler_pkg::*;

  localparam int unsigned LW = 8;

  logic clock = 1'b0;
  logic resetN = 1'b0;

  sobel_line_scheduler_if bus();

  sobel_line_scheduler #(.LINE_WORDS(LW)) dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  // Line buffers: synchronous write, registered read.
  logic [15:0] mem0 [256];
  logic [15:0] mem1 [256];
  logic [15:0] mem2 [256];

  always @(posedge clock) begin
    if (bus.bufWriteEnable[0]) mem0[bus.bufAddressIn] <= bus.bufDataIn;
    if (bus.bufWriteEnable[1]) mem1[bus.bufAddressIn] <= bus.bufDataIn;
    if (bus.bufWriteEnable[2]) mem2[bus.bufAddressIn] <= bus.bufDataIn;
    bus.bufDataOut0 <= mem0[bus.bufAddressOut];
    bus.bufDataOut1 <= mem1[bus.bufAddressOut];
    bus.bufDataOut2 <= mem2[bus.bufAddressOut];
  end

  typedef struct packed {
    logic        valid;
    logic [15:0] t;
    logic [15:0] m;
    logic [15:0] b;
    logic [7:0]  col;
    logic        last;
  } win_t;

  int checks = 0;
  int errors = 0;

  bit          inFrame = 0;
  int          lineNo = 0;
  int          colCnt = 0;
  bit          ovfM = 0;
  logic [15:0] hist [64][LW];
  win_t        pipe0 = '0;
  win_t        outExp = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, update the reference, check the
  // combinational buffer controls, then the registered outputs after the edge.
  task automatic step(input bit rn, input bit fs, input bit pv, input bit le, input logic [15:0] d);
    win_t        newE;
    bit          acc;
    logic [2:0]  expWe;
    int          expAddr;
    resetN         = rn;
    bus.frameStart = fs;
    bus.pixelValid = pv;
    bus.lineEnd    = le;
    bus.pixelData  = d;
    newE    = '0;
    acc     = 0;
    expWe   = 3'b000;
    expAddr = 0;
    if (!rn) begin
      inFrame = 0;
      lineNo  = 0;
      colCnt  = 0;
      ovfM    = 0;
      pipe0   = '0;
      outExp  = '0;
    end else begin
      if (fs) begin
        inFrame = 1;
        lineNo  = 0;
        colCnt  = 0;
        ovfM    = 0;
        pipe0   = '0;
      end
      if (inFrame && pv) begin
        if (colCnt < LW) begin
          acc     = 1;
          expWe   = 3'(1 << (lineNo % 3));
          expAddr = colCnt;
          hist[lineNo % 64][colCnt] = d;
          if (lineNo >= 2) begin
            newE.valid = 1'b1;
            newE.t     = hist[(lineNo - 2) % 64][colCnt];
            newE.m     = hist[(lineNo - 1) % 64][colCnt];
            newE.b     = d;
            newE.col   = 8'(colCnt);
            newE.last  = le;
          end
        end else begin
          ovfM = 1;
        end
        if (le) begin
          lineNo++;
          colCnt = 0;
        end else begin
          colCnt++;
        end
      end
      outExp = pipe0;
      pipe0  = newE;
    end
    #1;
    chk("bufWriteEnable", bus.bufWriteEnable, expWe);
    if (acc) begin
      chk("bufAddressIn", bus.bufAddressIn, expAddr);
      chk("bufAddressOut", bus.bufAddressOut, expAddr);
      chk("bufDataIn", bus.bufDataIn, d);
    end
    @(posedge clock);
    #1;
    chk("windowValid", bus.windowValid, outExp.valid);
    chk("overflow", bus.overflow, ovfM);
    if (outExp.valid) begin
      chk("top", bus.top, outExp.t);
      chk("middle", bus.middle, outExp.m);
      chk("bottom", bus.bottom, outExp.b);
      chk("windowColumn", bus.windowColumn, outExp.col);
      chk("lastColumn", bus.lastColumn, outExp.last);
    end
    if (!rn) begin
      chk("reset_top", bus.top, 16'h0);
      chk("reset_middle", bus.middle, 16'h0);
      chk("reset_bottom", bus.bottom, 16'h0);
      chk("reset_windowColumn", bus.windowColumn, 8'h0);
      chk("reset_lastColumn", bus.lastColumn, 1'b0);
    end
  endtask

  task automatic idle();
    step(1, 0, 0, 1'($urandom_range(0, 1)), 16'($urandom));
  endtask

  // gapMode: 0 none, 1 gap after every word, 2 random gaps.
  // tag >= 0 gives data tag*16+col, otherwise random data.
  task automatic line(input int n, input int tag, input int gapMode, input bit fsFirst);
    logic [15:0] d;
    for (int c = 0; c < n; c++) begin
      if (gapMode == 2 && $urandom_range(0, 3) == 0) idle();
      d = (tag >= 0) ? 16'(tag * 16 + c) : 16'($urandom);
      step(1, fsFirst && (c == 0), 1, c == n - 1, d);
      if (gapMode == 1 && c < n - 1) idle();
    end
  endtask

  initial begin
    // Reset, then words while IDLE must not be written.
    step(0, 0, 0, 0, 16'h0);
    step(0, 0, 1, 0, 16'h1234);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 1'($urandom_range(0, 1)), 16'($urandom));

    // Fill: three lines of word = line*16 + col.
    step(1, 1, 0, 0, 16'h0);
    line(8, 0, 0, 0);
    line(8, 1, 0, 0);
    line(8, 2, 0, 0);

    // Rotation with alternating gaps on line 3, random gaps afterwards.
    line(8, -1, 1, 0);
    for (int k = 4; k < 9; k++) line(8, -1, 2, 0);

    // Overflow: 10 words in one line, then a normal line.
    line(10, -1, 0, 0);
    line(8, -1, 2, 0);

    // Restart mid-line with a valid word on the frameStart cycle.
    for (int c = 0; c < 3; c++) step(1, 0, 1, 0, 16'($urandom));
    line(8, -1, 0, 1);
    for (int k = 0; k < 3; k++) line(8, -1, 2, 0);

    // Reset mid-stream, IDLE until the next frameStart.
    for (int c = 0; c < 4; c++) step(1, 0, 1, 0, 16'($urandom));
    step(0, 0, 1, 0, 16'($urandom));
    for (int c = 0; c < 4; c++) step(1, 0, 1, 1'(c == 3), 16'($urandom));
    step(1, 1, 0, 0, 16'h0);
    for (int k = 0; k < 3; k++) line(8, -1, 2, 0);
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sobel_line_scheduler.md
# sobel_line_scheduler

Sequencing controller for the three 256×16 dual-port Sobel line buffers in the camera path. It writes each incoming 16-bit pixel word into the buffer holding the current line and reads the same column from the two previous lines. It rotates buffer roles at every line end and emits a column-aligned top/middle/bottom word triple to the Sobel kernel. It sits between the camera pixel stream and the Sobel arithmetic and owns all buffer address and write-enable generation.

## Interface
- `LINE_WORDS`, 256: maximum words per line; legal range 4..256; addresses are 8 bit.
- `clock`  in  1  single system clock; the buffers' write and read clocks are tied to it.
- `resetN`  in  1  synchronous, active-low reset.
- `frameStart`  in  1  one-cycle pulse; aborts the current frame and restarts fill.
- `pixelValid`  in  1  `pixelData` is valid this cycle; no backpressure.
- `lineEnd`  in  1  qualified by `pixelValid`; marks the last word of a line.
- `pixelData`  in  16  incoming pixel word.
- `bufAddressIn`  out  8  write address shared by all three buffers.
- `bufWriteEnable`  out  3  one-hot write enable; bit k selects buffer k.
- `bufDataIn`  out  16  write data, equal to `pixelData`.
- `bufAddressOut`  out  8  read address shared by all three buffers.
- `bufDataOut0..2`  in  16 each  registered read data from buffers 0..2.
- `top`, `middle`, `bottom`  out  16 each  window column for lines n-2, n-1 and n.
- `windowValid`  out  1  the triple is valid.
- `windowColumn`  out  8  column index of the triple.
- `lastColumn`  out  1  the triple is the last column of its line.
- `overflow`  out  1  sticky flag: a line exceeded `LINE_WORDS`; cleared by reset or `frameStart`.

## Operation
- States:
  - IDLE → FILL0 on `frameStart`.
  - FILL0 → FILL1 on the first accepted `lineEnd`.
  - FILL1 → STREAM on the second accepted `lineEnd`.
  - STREAM stays in STREAM on every later `lineEnd`.
  - `frameStart` in any state → FILL0.
- Column counter `col` (8 bit): increments on each accepted word and clears on `lineEnd` or `frameStart`. It saturates at `LINE_WORDS-1`.
- Words arriving after saturation and before `lineEnd`:
  - are not written (`bufWriteEnable` = 0);
  - set `overflow`;
  - produce no window.
- Role register `cur` (2 bit, values 0..2): names the buffer for line n. Line n-1 is buffer `(cur+2) mod 3` and line n-2 is buffer `(cur+1) mod 3`.
  - On each accepted `lineEnd`, `cur` ← `(cur+1) mod 3`.
  - `frameStart` sets `cur` to 0.
- Accepted word: `bufWriteEnable[cur]` = 1, and `bufAddressIn` = `bufAddressOut` = `col`, both combinational from the counter.
- Windows are produced only in STREAM. The role indices are captured at the cycle the word is accepted, so a rotation in that same cycle does not corrupt the triple.
- `lineEnd` without `pixelValid` is ignored.
- `frameStart` together with `pixelValid`: the word is column 0 of the new frame, and any in-flight triple is dropped.

## Timing
- Reset values:
  - `windowValid`, `lastColumn`, `overflow` = 0;
  - `top`, `middle`, `bottom`, `windowColumn` = 0;
  - `bufWriteEnable` = 0;
  - `col` = 0, `cur` = 0, state IDLE.
- Latency: a word accepted at cycle t gives a triple with `windowValid` = 1 at cycle t+2.
  - t+1: buffer read data returns.
  - t+2: the mux result is registered.
  - `bottom` is `pixelData` delayed two cycles.
- Read-during-write: the same address in the same cycle only ever hits buffer `cur`, which is never read for this window. No hazard.
- Gaps in `pixelValid` insert matching gaps in `windowValid`. Throughput is one word per cycle.
- `resetN` low mid-line: all state is cleared next edge, and no further writes are issued.

## Structure
- A shared package holds:
  - state encoding (IDLE, FILL0, FILL1, STREAM);
  - the `LINE_WORDS` default;
  - the address width of 8;
  - a `nextRole(cur)` mod-3 increment function.
- One natural sub-module: `sobel_window_mux`. It is the two-stage pipeline that registers the role indices, selects among `bufDataOut0..2`, and delays `bottom`, `windowColumn` and `lastColumn`.
- The three buffer instances live in the parent, not inside this block.

## Test plan
- Fill: `frameStart`, then 3 lines of 8 words with word = line×16 + col.
  - No `windowValid` during lines 0–1.
  - Line 2, col 5 gives `top`=0x05, `middle`=0x15, `bottom`=0x25 at t+2.
- Rotation: stream 6 lines of 8 words. Each line k≥2 gives `top`/`middle`/`bottom` from lines k-2/k-1/k. `cur` cycles 0,1,2,0.
- Gaps: toggle `pixelValid` every other cycle on line 3. Triples stay correct, `windowValid` shows the same gap pattern, and `windowColumn` runs 0..7.
- Overflow: `LINE_WORDS`=8, send 10 words then `lineEnd`.
  - Only 8 writes occur and `overflow` = 1.
  - The last window column is 7 with `lastColumn` = 0; `lastColumn` = 1 only when `lineEnd` hits col 7.
- Restart: `frameStart` mid line 4 together with `pixelValid`.
  - State goes to FILL0 and `overflow` clears.
  - No `windowValid` until the new frame's third line.
  - That word is written at address 0 of buffer 0.
- Reset: assert `resetN`=0 for 1 cycle mid-stream. All outputs and `bufWriteEnable` are 0 the next cycle, and the block stays IDLE until `frameStart`.
